dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU memory-access stage (port C) and a debug/DMA master (port D).
- Sits between stage_memory's dmem_* outputs and the data RAM.
- Grants one requester per cycle. The CPU has priority, with a starvation guard for port D.
- Tracks in-flight reads so that returning read data is steered to the requester that issued the read. The pipeline uses cpu_grant_o to stall.

Parameters:
- READ_LATENCY, 1, cycles from dmem_read_enable_o to valid dmem_read_data_i (legal 1..4).
- STARVE_LIMIT, 4, consecutive denied cycles of port D after which D takes priority (legal 1..15).

Ports:
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous active-low reset
- cpu_addr_i  input  32  CPU byte address
- cpu_read_enable_i  input  1  CPU load request
- cpu_write_data_i  input  32  CPU store data, already lane-shifted
- cpu_write_mask_i  input  4  CPU byte write enables
- cpu_grant_o  output  1  CPU access issued this cycle
- cpu_read_data_o  output  32  load data returned to CPU
- cpu_read_valid_o  output  1  cpu_read_data_o valid
- dbg_req_i  input  1  port D request
- dbg_write_i  input  1  port D request is a write
- dbg_addr_i  input  32  port D byte address
- dbg_write_data_i  input  32  port D write data
- dbg_write_mask_i  input  4  port D byte enables
- dbg_grant_o  output  1  port D access issued this cycle
- dbg_read_data_o  output  32  read data to port D
- dbg_read_valid_o  output  1  dbg_read_data_o valid
- dmem_addr_o  output  32  word address to RAM
- dmem_read_enable_o  output  1  RAM read enable
- dmem_write_data_o  output  32  RAM write data
- dmem_write_mask_o  output  4  RAM byte write enables
- dmem_read_data_i  input  32  RAM read data

Behaviour:
- Request definitions:
  - cpu_req = cpu_read_enable_i | (|cpu_write_mask_i).
  - A D request is dbg_req_i. A D write with a zero mask is still granted and writes nothing.
- Arbitration is combinational within the cycle:
  - D wins if (dbg_req_i & starve_q == STARVE_LIMIT) or (dbg_req_i & !cpu_req).
  - Otherwise C wins if cpu_req.
  - At most one grant is high in any cycle.
  - A request that is not granted is ignored. The requester must hold it stable until granted.
- Starve counter starve_q (4 bits, saturating at STARVE_LIMIT):
  - Increments when dbg_req_i is high and dbg_grant_o is low.
  - Clears when dbg_grant_o is high or dbg_req_i is low.
- Memory drive for the winner:
  - dmem_addr_o = {addr[31:2], 2'b00}.
  - dmem_read_enable_o is high for a C read or a D read (!dbg_write_i).
  - dmem_write_mask_o and dmem_write_data_o come from the winner. For a D read, the mask is 0.
  - If a CPU request has both a read and a mask set, the mask is honoured and the read is also issued.
- Idle (no grant): dmem_addr_o = 0, dmem_read_enable_o = 0, dmem_write_mask_o = 0, dmem_write_data_o = 0.
- Read-return tracking:
  - A READ_LATENCY-deep shift register of {valid, owner} entries.
  - Entry 0 is loaded each cycle with {dmem_read_enable_o, winner_is_D}.
  - The tail entry drives the outputs: cpu_read_valid_o = tail.valid & !tail.owner, and dbg_read_valid_o = tail.valid & tail.owner.
  - Both read_data outputs always equal dmem_read_data_i. Consumers qualify them with the valid signals.
- Back-to-back reads from alternating owners are legal. Returns come back in issue order, one per cycle, with no bubbles.
- Writes never produce a read_valid.
- Reset, asynchronous and active-low:
  - Clears starve_q and all tracker entries.
  - Grants follow the inputs combinationally.
  - cpu_read_valid_o = 0 and dbg_read_valid_o = 0 while reset is asserted and in the first cycle after release.
  - Reads in flight when reset asserts are discarded and never returned.
- Counter boundary: with STARVE_LIMIT = 1, D is granted on alternate cycles under continuous C traffic.

Decomposition:
- cpu_common package gets:
  - typedef dmem_owner_t (enum DMEM_OWNER_CPU = 0, DMEM_OWNER_DBG = 1)
  - typedef dmem_tag_t (packed struct {valid, owner})
  - constant DMEM_MAX_READ_LATENCY = 4
- One natural sub-module, dmem_read_tracker: the parameterised tag shift register. Inputs are the issue tag; outputs are the tail tag. Reset is async active-low.
- Arbitration and the starve counter stay in dmem_arbiter.

Test Plan:
- CPU read only, addr 0x103, READ_LATENCY 1:
  - cpu_grant_o = 1 and dmem_addr_o = 0x100 in cycle N.
  - In cycle N+1, cpu_read_valid_o = 1 and cpu_read_data_o = RAM word; dbg_read_valid_o stays 0.
- D write alone (addr 0x40, data 0xDEADBEEF, mask 4'b1111):
  - dbg_grant_o = 1 and dmem_write_mask_o = 4'b1111 the same cycle.
  - No read_valid follows.
- Continuous CPU requests, D requests from cycle 0, STARVE_LIMIT 4:
  - dbg_grant_o first asserts in cycle 4, with cpu_grant_o = 0 in that cycle.
  - CPU is re-granted in cycle 5, and starve_q = 0.
- READ_LATENCY 3, reads issued C, D, C in cycles 0, 1, 2:
  - cpu_read_valid_o pulses in cycles 3 and 5.
  - dbg_read_valid_o pulses in cycle 4.
- Reset asserted one cycle after a CPU read issue with READ_LATENCY 2:
  - No cpu_read_valid_o ever pulses for that read.
  - After release, a fresh read returns normally.
- No requests for 10 cycles: all dmem outputs stay 0 and both grants stay 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_common : shared types for the data-memory arbiter and tracker  |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_common;

  typedef enum logic {
    DMEM_OWNER_CPU = 1'b0,
    DMEM_OWNER_DBG = 1'b1
  } dmem_owner_t;

  typedef struct packed {
    logic        valid;
    dmem_owner_t owner;
  } dmem_tag_t;

  localparam int DMEM_MAX_READ_LATENCY = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_read_tracker.sv
// +--------------------------------------------------------------------+
// | dmem_read_tracker : delays each read's owner tag by LATENCY cycles  |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_read_tracker
  import cpu_common::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic issue_valid,
  input  logic issue_owner,
  output logic tail_valid,
  output logic tail_owner
);

  dmem_tag_t r_tags [LATENCY];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < LATENCY; i++) r_tags[i] <= '0;
    end else begin
      r_tags[0] <= '{valid: issue_valid, owner: dmem_owner_t'(issue_owner)};
      for (int i = 1; i < LATENCY; i++) r_tags[i] <= r_tags[i-1];
    end
  end

  assign tail_valid = r_tags[LATENCY-1].valid;
  assign tail_owner = (r_tags[LATENCY-1].owner == DMEM_OWNER_DBG);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +--------------------------------------------------------------------+
// | dmem_arbiter : CPU-priority data-memory arbiter with debug starve   |
// |                guard and in-order read-return steering              |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter
  import cpu_common::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_read_enable_i,
  input  logic [31:0] cpu_write_data_i,
  input  logic [3:0]  cpu_write_mask_i,
  output logic        cpu_grant_o,
  output logic [31:0] cpu_read_data_o,
  output logic        cpu_read_valid_o,
  input  logic        dbg_req_i,
  input  logic        dbg_write_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_write_data_i,
  input  logic [3:0]  dbg_write_mask_i,
  output logic        dbg_grant_o,
  output logic [31:0] dbg_read_data_o,
  output logic        dbg_read_valid_o,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_read_enable_o,
  output logic [31:0] dmem_write_data_o,
  output logic [3:0]  dmem_write_mask_o,
  input  logic [31:0] dmem_read_data_i
);

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;
  logic       w_cpu_req;
  logic       w_dbg_win;
  logic       w_cpu_win;
  logic       w_tail_valid;
  logic       w_tail_owner;
  logic       w_unused_addr_bits;

  assign w_cpu_req = cpu_read_enable_i | (|cpu_write_mask_i);
  assign w_dbg_win = dbg_req_i & ((r_starve == C_STARVE_LIMIT) | ~w_cpu_req);
  assign w_cpu_win = w_cpu_req & ~w_dbg_win;

  assign cpu_grant_o = w_cpu_win;
  assign dbg_grant_o = w_dbg_win;

  // Counts consecutive denied cycles of port D; saturates at the limit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_starve <= '0;
    end else if (dbg_req_i && !w_dbg_win) begin
      if (r_starve != C_STARVE_LIMIT) r_starve <= r_starve + 4'd1;
    end else begin
      r_starve <= '0;
    end
  end

  always_comb begin
    dmem_addr_o        = '0;
    dmem_read_enable_o = 1'b0;
    dmem_write_data_o  = '0;
    dmem_write_mask_o  = '0;
    if (w_dbg_win) begin
      dmem_addr_o        = {dbg_addr_i[31:2], 2'b00};
      dmem_read_enable_o = ~dbg_write_i;
      dmem_write_data_o  = dbg_write_data_i;
      dmem_write_mask_o  = dbg_write_i ? dbg_write_mask_i : 4'b0000;
    end else if (w_cpu_win) begin
      dmem_addr_o        = {cpu_addr_i[31:2], 2'b00};
      dmem_read_enable_o = cpu_read_enable_i;
      dmem_write_data_o  = cpu_write_data_i;
      dmem_write_mask_o  = cpu_write_mask_i;
    end
  end

  assign w_unused_addr_bits = ^{cpu_addr_i[1:0], dbg_addr_i[1:0]};

  dmem_read_tracker #(
    .LATENCY (READ_LATENCY)
  ) u_tracker (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .issue_valid (dmem_read_enable_o),
    .issue_owner (w_dbg_win),
    .tail_valid  (w_tail_valid),
    .tail_owner  (w_tail_owner)
  );

  assign cpu_read_valid_o = w_tail_valid & ~w_tail_owner;
  assign dbg_read_valid_o = w_tail_valid & w_tail_owner;
  assign cpu_read_data_o  = dmem_read_data_i;
  assign dbg_read_data_o  = dmem_read_data_i;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_dmem_arbiter : three arbiter instances (latency/limit variants)  |
// |                   checked against a behavioural model every cycle   |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;

  localparam int N = 3;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, rdata;
  logic        cpu_re, dbg_req, dbg_wr;
  logic [3:0]  cpu_mask, dbg_mask;

  logic [N-1:0] cgnt, cval, dgnt, dval, dre;
  logic [31:0]  crd [N];
  logic [31:0]  drd [N];
  logic [31:0]  daddr [N];
  logic [31:0]  dwd [N];
  logic [3:0]   dmask [N];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Instance 0: latency 1 / limit 4, instance 1: latency 3 / limit 4, instance 2: latency 2 / limit 1
  function automatic int rl(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction
  function automatic int sl(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  always #5 clk = ~clk;

  dmem_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clk_i(clk), .reset_ni(rst_n),
    .cpu_addr_i(cpu_addr), .cpu_read_enable_i(cpu_re), .cpu_write_data_i(cpu_wdata),
    .cpu_write_mask_i(cpu_mask), .cpu_grant_o(cgnt[0]), .cpu_read_data_o(crd[0]),
    .cpu_read_valid_o(cval[0]), .dbg_req_i(dbg_req), .dbg_write_i(dbg_wr),
    .dbg_addr_i(dbg_addr), .dbg_write_data_i(dbg_wdata), .dbg_write_mask_i(dbg_mask),
    .dbg_grant_o(dgnt[0]), .dbg_read_data_o(drd[0]), .dbg_read_valid_o(dval[0]),
    .dmem_addr_o(daddr[0]), .dmem_read_enable_o(dre[0]), .dmem_write_data_o(dwd[0]),
    .dmem_write_mask_o(dmask[0]), .dmem_read_data_i(rdata));

  dmem_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clk_i(clk), .reset_ni(rst_n),
    .cpu_addr_i(cpu_addr), .cpu_read_enable_i(cpu_re), .cpu_write_data_i(cpu_wdata),
    .cpu_write_mask_i(cpu_mask), .cpu_grant_o(cgnt[1]), .cpu_read_data_o(crd[1]),
    .cpu_read_valid_o(cval[1]), .dbg_req_i(dbg_req), .dbg_write_i(dbg_wr),
    .dbg_addr_i(dbg_addr), .dbg_write_data_i(dbg_wdata), .dbg_write_mask_i(dbg_mask),
    .dbg_grant_o(dgnt[1]), .dbg_read_data_o(drd[1]), .dbg_read_valid_o(dval[1]),
    .dmem_addr_o(daddr[1]), .dmem_read_enable_o(dre[1]), .dmem_write_data_o(dwd[1]),
    .dmem_write_mask_o(dmask[1]), .dmem_read_data_i(rdata));

  dmem_arbiter #(.READ_LATENCY(2), .STARVE_LIMIT(1)) u_c (
    .clk_i(clk), .reset_ni(rst_n),
    .cpu_addr_i(cpu_addr), .cpu_read_enable_i(cpu_re), .cpu_write_data_i(cpu_wdata),
    .cpu_write_mask_i(cpu_mask), .cpu_grant_o(cgnt[2]), .cpu_read_data_o(crd[2]),
    .cpu_read_valid_o(cval[2]), .dbg_req_i(dbg_req), .dbg_write_i(dbg_wr),
    .dbg_addr_i(dbg_addr), .dbg_write_data_i(dbg_wdata), .dbg_write_mask_i(dbg_mask),
    .dbg_grant_o(dgnt[2]), .dbg_read_data_o(drd[2]), .dbg_read_valid_o(dval[2]),
    .dmem_addr_o(daddr[2]), .dmem_read_enable_o(dre[2]), .dmem_write_data_o(dwd[2]),
    .dmem_write_mask_o(dmask[2]), .dmem_read_data_i(rdata));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: per-instance denial count and a calendar of expected read returns.
  int deny [N];
  bit exp_cv [N][MAXC];
  bit exp_dv [N][MAXC];

  always @(negedge clk) begin : p_cmp
    bit creq, dwin, cwin, ere, chkdata;
    logic [31:0] ea, ed;
    logic [3:0] em;
    for (int k = 0; k < N; k++) begin
      creq = cpu_re | (|cpu_mask);
      dwin = dbg_req && ((deny[k] >= sl(k)) || !creq);
      cwin = creq && !dwin;
      ea = '0; ed = '0; em = '0; ere = 1'b0; chkdata = 1'b1;
      if (dwin) begin
        ea = dbg_addr & 32'hFFFF_FFFC;
        ere = !dbg_wr;
        em = dbg_wr ? dbg_mask : 4'h0;
        ed = dbg_wdata;
        chkdata = dbg_wr;
      end else if (cwin) begin
        ea = cpu_addr & 32'hFFFF_FFFC;
        ere = cpu_re;
        em = cpu_mask;
        ed = cpu_wdata;
      end
      chk($sformatf("m%0d.cpu_grant", k), 32'(cgnt[k]), 32'(cwin));
      chk($sformatf("m%0d.dbg_grant", k), 32'(dgnt[k]), 32'(dwin));
      chk($sformatf("m%0d.dmem_addr", k), daddr[k], ea);
      chk($sformatf("m%0d.dmem_re", k), 32'(dre[k]), 32'(ere));
      chk($sformatf("m%0d.dmem_mask", k), 32'(dmask[k]), 32'(em));
      if (chkdata) chk($sformatf("m%0d.dmem_wdata", k), dwd[k], ed);
      chk($sformatf("m%0d.cpu_rdata", k), crd[k], rdata);
      chk($sformatf("m%0d.dbg_rdata", k), drd[k], rdata);
      chk($sformatf("m%0d.cpu_rvalid", k), 32'(cval[k]), 32'(rst_n & exp_cv[k][cyc]));
      chk($sformatf("m%0d.dbg_rvalid", k), 32'(dval[k]), 32'(rst_n & exp_dv[k][cyc]));
      if (!rst_n) begin
        deny[k] = 0;
        for (int j = 0; j <= 4; j++) begin
          exp_cv[k][cyc+j] = 1'b0;
          exp_dv[k][cyc+j] = 1'b0;
        end
      end else begin
        if (ere) begin
          if (dwin) exp_dv[k][cyc+rl(k)] = 1'b1;
          else      exp_cv[k][cyc+rl(k)] = 1'b1;
        end
        if (dbg_req && !dwin) deny[k] = (deny[k] + 1 > sl(k)) ? sl(k) : deny[k] + 1;
        else deny[k] = 0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rdata = $urandom;
  endtask

  task automatic idle_in();
    cpu_re = 0; cpu_mask = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0; dbg_mask = 0;
  endtask

  initial begin
    idle_in();
    rdata = 32'h1234_5678;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) deny[k] = 0;
    tick();
    @(negedge clk);
    chk("reset.cpu_rvalid", 32'(cval), 32'd0);
    chk("reset.dbg_rvalid", 32'(dval), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset.cpu_rvalid", 32'(cval), 32'd0);

    // Idle: everything stays zero
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("idle.grants", 32'({cgnt, dgnt}), 32'd0);
      chk("idle.addr", daddr[0] | daddr[1] | daddr[2], 32'd0);
      chk("idle.re_mask", 32'({dre, dmask[0], dmask[1], dmask[2]}), 32'd0);
    end

    // CPU read of 0x103 with latency 1
    tick();
    cpu_re = 1; cpu_addr = 32'h103; cpu_wdata = 32'h0;
    @(negedge clk);
    chk("c_read.grant", 32'(cgnt[0]), 32'd1);
    chk("c_read.addr", daddr[0], 32'h100);
    tick();
    idle_in();
    @(negedge clk);
    chk("c_read.rvalid", 32'(cval[0]), 32'd1);
    chk("c_read.rdata", crd[0], rdata);
    chk("c_read.dvalid", 32'(dval[0]), 32'd0);

    // D write alone
    tick();
    dbg_req = 1; dbg_wr = 1; dbg_addr = 32'h40; dbg_wdata = 32'hDEAD_BEEF; dbg_mask = 4'hF;
    @(negedge clk);
    chk("d_write.grant", 32'(dgnt[0]), 32'd1);
    chk("d_write.mask", 32'(dmask[0]), 32'hF);
    chk("d_write.data", dwd[0], 32'hDEAD_BEEF);
    // D write with zero mask is still granted
    tick();
    dbg_mask = 4'h0;
    @(negedge clk);
    chk("d_write0.grant", 32'(dgnt[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_in();
      @(negedge clk);
      chk("d_write.no_rvalid", 32'({cval, dval}), 32'd0);
    end

    // Continuous CPU traffic with D pending from cycle 0
    for (int i = 0; i < 10; i++) begin
      tick();
      cpu_re = 1; cpu_addr = 32'h300 + 32'(4 * i); cpu_mask = (i == 2) ? 4'b0011 : 4'b0000;
      cpu_wdata = 32'hC0DE_0000 + 32'(i);
      dbg_req = 1; dbg_wr = 0; dbg_addr = 32'h201;
      @(negedge clk);
      chk($sformatf("starve4.dgrant[%0d]", i), 32'(dgnt[0]), 32'(i == 4 || i == 9));
      chk($sformatf("starve4.cgrant[%0d]", i), 32'(cgnt[0]), 32'(!(i == 4 || i == 9)));
      chk($sformatf("starve1.dgrant[%0d]", i), 32'(dgnt[2]), 32'(i % 2 == 1));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_in();
      @(negedge clk);
    end

    // Latency 3: reads C, D, C in cycles 0..2
    for (int i = 0; i < 7; i++) begin
      tick();
      idle_in();
      if (i == 0) begin cpu_re = 1; cpu_addr = 32'h10; end
      if (i == 1) begin dbg_req = 1; dbg_addr = 32'h20; end
      if (i == 2) begin cpu_re = 1; cpu_addr = 32'h30; end
      @(negedge clk);
      chk($sformatf("lat3.cvalid[%0d]", i), 32'(cval[1]), 32'(i == 3 || i == 5));
      chk($sformatf("lat3.dvalid[%0d]", i), 32'(dval[1]), 32'(i == 4));
    end

    // Reset one cycle after a CPU read on the latency-2 instance
    tick();
    cpu_re = 1; cpu_addr = 32'h80;
    @(negedge clk);
    tick();
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_flush.c1", 32'(cval[2]), 32'd0);
    tick();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_flush.after", 32'(cval[2]), 32'd0);
      tick();
    end
    cpu_re = 1; cpu_addr = 32'h84;
    @(negedge clk);
    tick();
    idle_in();
    @(negedge clk);
    chk("rst_fresh.early", 32'(cval[2]), 32'd0);
    tick();
    @(negedge clk);
    chk("rst_fresh.rvalid", 32'(cval[2]), 32'd1);
    chk("rst_fresh.rdata", crd[2], rdata);

    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
